// File: rtl/axi_crc_regbank_if.sv
// AXI4 write/read channel bundle for the CRC register bank.
interface axi_crc_regbank_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] awid_i;
  logic [31:0]     awaddr_i;
  logic [7:0]      awlen_i;
  logic            awvalid_i;
  logic            awready_o;
  logic [31:0]     wdata_i;
  logic [3:0]      wstrb_i;
  logic            wlast_i;
  logic            wvalid_i;
  logic            wready_o;
  logic [ID_W-1:0] bid_o;
  logic [1:0]      bresp_o;
  logic            bvalid_o;
  logic            bready_i;
  logic [ID_W-1:0] arid_i;
  logic [31:0]     araddr_i;
  logic [7:0]      arlen_i;
  logic            arvalid_i;
  logic            arready_o;
  logic [ID_W-1:0] rid_o;
  logic [31:0]     rdata_o;
  logic [1:0]      rresp_o;
  logic            rlast_o;
  logic            rvalid_o;
  logic            rready_i;

  modport slave (
    input  awid_i, awaddr_i, awlen_i, awvalid_i, wdata_i, wstrb_i, wlast_i, wvalid_i,
           bready_i, arid_i, araddr_i, arlen_i, arvalid_i, rready_i,
    output awready_o, wready_o, bid_o, bresp_o, bvalid_o, arready_o,
           rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
  );

  modport master (
    output awid_i, awaddr_i, awlen_i, awvalid_i, wdata_i, wstrb_i, wlast_i, wvalid_i,
           bready_i, arid_i, araddr_i, arlen_i, arvalid_i, rready_i,
    input  awready_o, wready_o, bid_o, bresp_o, bvalid_o, arready_o,
           rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
  );
endinterface

// File: rtl/axi_crc_regbank.sv
// AXI4 register bank with a background CRC-32 over all registers, exposed
// read-only at index NUM_REGS and on crc_o.
module axi_crc_regbank #(
  parameter int NUM_REGS = 8,
  parameter int ID_W     = 4
) (
  input  logic               clk,
  input  logic               areset,
  axi_crc_regbank_if.slave   s,
  output logic [31:0]        crc_o
);
  localparam int          CW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [29:0] CRC_IDX = 30'(NUM_REGS);
  localparam logic [1:0]  OKAY    = 2'b00;
  localparam logic [1:0]  SLVERR  = 2'b10;
  localparam logic [31:0] POLY    = 32'hEDB88320;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic       {C_IDLE, C_RUN}          c_state_t;

  w_state_t w_state;
  r_state_t r_state;
  c_state_t c_state;

  logic [NUM_REGS-1:0][31:0] regs;
  logic [ID_W-1:0] w_id;
  logic [29:0]     w_idx, r_idx;
  logic            w_err;
  logic [7:0]      r_left;
  logic            dirty;
  logic [31:0]     c_acc, c_nxt;
  logic [CW-1:0]   c_cnt;

  logic        w_beat, w_hit, reg_wr, c_clean;
  logic [29:0] ar_idx;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s.awaddr_i[1:0], s.araddr_i[1:0]};
  assign w_beat  = s.wready_o && s.wvalid_i;
  assign w_hit   = w_idx < CRC_IDX;
  assign reg_wr  = w_beat && w_hit && (|s.wstrb_i);
  assign c_clean = (c_state == C_IDLE) && !dirty;
  assign ar_idx  = s.araddr_i[31:2];

  // Bits consumed LSB first over the word == bytes LSB first, reflected.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] x;
    x = c;
    for (int i = 0; i < 32; i++)
      x = (x >> 1) ^ ((x[0] ^ d[i]) ? POLY : 32'h0);
    return x;
  endfunction

  function automatic logic [33:0] rd_lookup(input logic [29:0] idx);
    if (idx < CRC_IDX)       return {OKAY, regs[idx[CW-1:0]]};
    else if (idx == CRC_IDX) return {OKAY, crc_o};
    else                     return {SLVERR, 32'h0};
  endfunction

  always_comb c_nxt = crc_step(c_acc, regs[c_cnt]);

  // Write channel and register storage.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      w_state     <= W_IDLE;
      s.awready_o <= 1'b1;
      s.wready_o  <= 1'b0;
      s.bvalid_o  <= 1'b0;
      s.bid_o     <= '0;
      s.bresp_o   <= OKAY;
      w_id        <= '0;
      w_idx       <= '0;
      w_err       <= 1'b0;
      regs        <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (s.awvalid_i) begin
          w_id        <= s.awid_i;
          w_idx       <= s.awaddr_i[31:2];
          w_err       <= 1'b0;
          s.awready_o <= 1'b0;
          s.wready_o  <= 1'b1;
          w_state     <= W_DATA;
        end
        W_DATA: if (w_beat) begin
          if (w_hit)
            for (int b = 0; b < 4; b++)
              if (s.wstrb_i[b]) regs[w_idx[CW-1:0]][8*b +: 8] <= s.wdata_i[8*b +: 8];
          w_idx <= w_idx + 30'd1;
          w_err <= w_err | !w_hit;
          if (s.wlast_i) begin
            s.wready_o <= 1'b0;
            s.bvalid_o <= 1'b1;
            s.bid_o    <= w_id;
            s.bresp_o  <= (w_err || !w_hit) ? SLVERR : OKAY;
            w_state    <= W_RESP;
          end
        end
        W_RESP: if (s.bready_i) begin
          s.bvalid_o  <= 1'b0;
          s.bresp_o   <= OKAY;
          s.awready_o <= 1'b1;
          w_state     <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel; data is captured at the launching edge so a same-edge
  // write still shows the old value.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_state     <= R_IDLE;
      s.arready_o <= 1'b1;
      s.rvalid_o  <= 1'b0;
      s.rlast_o   <= 1'b0;
      s.rdata_o   <= '0;
      s.rresp_o   <= OKAY;
      s.rid_o     <= '0;
      r_idx       <= '0;
      r_left      <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (s.arvalid_i) begin
          s.arready_o <= 1'b0;
          s.rid_o     <= s.arid_i;
          r_idx       <= ar_idx;
          r_left      <= s.arlen_i;
          if (ar_idx == CRC_IDX && !c_clean) begin
            r_state <= R_WAIT;
          end else begin
            {s.rresp_o, s.rdata_o} <= rd_lookup(ar_idx);
            s.rvalid_o <= 1'b1;
            s.rlast_o  <= (s.arlen_i == 8'd0);
            r_state    <= R_DATA;
          end
        end
        R_WAIT: if (c_clean) begin
          {s.rresp_o, s.rdata_o} <= rd_lookup(r_idx);
          s.rvalid_o <= 1'b1;
          s.rlast_o  <= (r_left == 8'd0);
          r_state    <= R_DATA;
        end
        R_DATA: if (s.rready_i) begin
          if (s.rlast_o) begin
            s.rvalid_o  <= 1'b0;
            s.rlast_o   <= 1'b0;
            s.rdata_o   <= '0;
            s.rresp_o   <= OKAY;
            s.arready_o <= 1'b1;
            r_state     <= R_IDLE;
          end else begin
            {s.rresp_o, s.rdata_o} <= rd_lookup(r_idx + 30'd1);
            r_idx     <= r_idx + 30'd1;
            r_left    <= r_left - 8'd1;
            s.rlast_o <= (r_left == 8'd1);
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // CRC engine; a write landing on the final run cycle restarts straight away.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      c_state <= C_IDLE;
      dirty   <= 1'b1;
      crc_o   <= '0;
      c_acc   <= 32'hFFFFFFFF;
      c_cnt   <= '0;
    end else begin
      case (c_state)
        C_IDLE: begin
          if (dirty) begin
            dirty   <= 1'b0;
            c_acc   <= 32'hFFFFFFFF;
            c_cnt   <= '0;
            c_state <= C_RUN;
          end else if (reg_wr) begin
            dirty <= 1'b1;
          end
        end
        C_RUN: begin
          if (c_cnt == CW'(NUM_REGS-1)) begin
            crc_o <= ~c_nxt;
            if (dirty || reg_wr) begin
              dirty <= 1'b0;
              c_acc <= 32'hFFFFFFFF;
              c_cnt <= '0;
            end else begin
              c_state <= C_IDLE;
            end
          end else begin
            c_acc <= c_nxt;
            c_cnt <= c_cnt + CW'(1);
            if (reg_wr) dirty <= 1'b1;
          end
        end
        default: c_state <= C_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_crc_regbank.sv
// Directed + randomized bench for axi_crc_regbank against a byte-level model.
module tb_axi_crc_regbank;
  localparam int N = 8;

  logic clk = 1'b0;
  logic areset = 1'b0;
  always #5 clk = ~clk;

  axi_crc_regbank_if #(.ID_W(4)) bus ();
  axi_crc_regbank_if #(.ID_W(4)) bus1 ();
  logic [31:0] crc, crc1;

  axi_crc_regbank #(.NUM_REGS(N), .ID_W(4)) dut (
    .clk(clk), .areset(areset), .s(bus.slave), .crc_o(crc));
  axi_crc_regbank #(.NUM_REGS(1), .ID_W(4)) dut1 (
    .clk(clk), .areset(areset), .s(bus1.slave), .crc_o(crc1));

  int tests = 0;
  int fails = 0;
  logic [31:0] mem [N];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Standard byte-wise IEEE CRC-32 over the model registers, low byte first.
  function automatic logic [31:0] crc_model();
    logic [31:0] c = 32'hFFFFFFFF;
    for (int r = 0; r < N; r++)
      for (int b = 0; b < 4; b++) begin
        c = c ^ {24'h0, mem[r][8*b +: 8]};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    return ~c;
  endfunction

  task automatic idle_in();
    bus.awid_i = '0; bus.awaddr_i = '0; bus.awlen_i = '0; bus.awvalid_i = 0;
    bus.wdata_i = '0; bus.wstrb_i = '0; bus.wlast_i = 0; bus.wvalid_i = 0; bus.bready_i = 0;
    bus.arid_i = '0; bus.araddr_i = '0; bus.arlen_i = '0; bus.arvalid_i = 0; bus.rready_i = 0;
    bus1.awid_i = '0; bus1.awaddr_i = '0; bus1.awlen_i = '0; bus1.awvalid_i = 0;
    bus1.wdata_i = '0; bus1.wstrb_i = '0; bus1.wlast_i = 0; bus1.wvalid_i = 0; bus1.bready_i = 0;
    bus1.arid_i = '0; bus1.araddr_i = '0; bus1.arlen_i = '0; bus1.arvalid_i = 0; bus1.rready_i = 0;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len);
    int g;
    logic [31:0] idx;
    bit err;
    bus.awid_i = id; bus.awaddr_i = addr; bus.awlen_i = 8'(len); bus.awvalid_i = 1;
    g = 0;
    while (!bus.awready_o && g < 200) begin tick(); g++; end
    if (g >= 200) chk("aw_timeout", 0, 1);
    tick();
    bus.awvalid_i = 0;
    idx = {2'b00, addr[31:2]};
    err = 0;
    for (int k = 0; k <= len; k++) begin
      bus.wdata_i = wd[k]; bus.wstrb_i = ws[k]; bus.wlast_i = (k == len); bus.wvalid_i = 1;
      g = 0;
      while (!bus.wready_o && g < 200) begin tick(); g++; end
      if (g >= 200) chk("w_timeout", 0, 1);
      tick();
      if (idx < N) begin
        for (int b = 0; b < 4; b++) if (ws[k][b]) mem[idx][8*b +: 8] = wd[k][8*b +: 8];
      end else err = 1;
      idx++;
    end
    bus.wvalid_i = 0; bus.wlast_i = 0;
    repeat ($urandom_range(0, 2)) tick();
    bus.bready_i = 1;
    g = 0;
    while (!bus.bvalid_o && g < 200) begin tick(); g++; end
    if (g >= 200) chk("b_timeout", 0, 1);
    chk("bresp", {30'h0, bus.bresp_o}, err ? 32'd2 : 32'd0);
    chk("bid", {28'h0, bus.bid_o}, {28'h0, id});
    tick();
    bus.bready_i = 0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len);
    int g;
    logic [31:0] idx, exp_d;
    logic [1:0]  exp_r;
    logic        first_vld;
    bus.arid_i = id; bus.araddr_i = addr; bus.arlen_i = 8'(len); bus.arvalid_i = 1;
    g = 0;
    while (!bus.arready_o && g < 200) begin tick(); g++; end
    if (g >= 200) chk("ar_timeout", 0, 1);
    tick();
    bus.arvalid_i = 0;
    first_vld = bus.rvalid_o;
    idx = {2'b00, addr[31:2]};
    if (idx != N) chk("r_first_latency", {31'h0, first_vld}, 1);
    for (int k = 0; k <= len; k++) begin
      g = 0;
      bus.rready_i = 1'($urandom_range(0, 1));
      while (!(bus.rvalid_o && bus.rready_i) && g < 400) begin
        tick(); g++;
        bus.rready_i = 1'($urandom_range(0, 1));
      end
      if (g >= 400) chk("r_timeout", 0, 1);
      if (idx < N)       begin exp_d = mem[idx];    exp_r = 2'b00; end
      else if (idx == N) begin exp_d = crc_model(); exp_r = 2'b00; end
      else               begin exp_d = 32'h0;       exp_r = 2'b10; end
      chk($sformatf("rdata[%0d]", idx), bus.rdata_o, exp_d);
      chk($sformatf("rresp[%0d]", idx), {30'h0, bus.rresp_o}, {30'h0, exp_r});
      chk($sformatf("rlast[%0d]", k), {31'h0, bus.rlast_o}, {31'h0, k == len});
      chk("rid", {28'h0, bus.rid_o}, {28'h0, id});
      tick();
      idx++;
    end
    bus.rready_i = 0;
  endtask

  initial begin
    int g;
    idle_in();
    for (int i = 0; i < N; i++) mem[i] = '0;
    repeat (3) tick();
    // reset state
    chk("rst_awready", {31'h0, bus.awready_o}, 1);
    chk("rst_arready", {31'h0, bus.arready_o}, 1);
    chk("rst_wready",  {31'h0, bus.wready_o}, 0);
    chk("rst_bvalid",  {31'h0, bus.bvalid_o}, 0);
    chk("rst_rvalid",  {31'h0, bus.rvalid_o}, 0);
    chk("rst_crc",     crc, 0);
    chk("rst_crc1",    crc1, 0);

    // CRC-index read straight after reset release must wait for the first run
    bus1.arid_i = 4'h3; bus1.araddr_i = 32'h4; bus1.arlen_i = 0; bus1.arvalid_i = 1;
    areset = 1;
    tick();
    bus1.arvalid_i = 0;
    chk("v1_wait", {31'h0, bus1.rvalid_o}, 0);
    g = 0;
    while (!bus1.rvalid_o && g < 50) begin tick(); g++; end
    if (g >= 50) chk("v1_timeout", 0, 1);
    chk("v1_rdata", bus1.rdata_o, 32'h2144DF1C);
    chk("v1_rresp", {30'h0, bus1.rresp_o}, 0);
    chk("v1_rlast", {31'h0, bus1.rlast_o}, 1);
    chk("v1_rid",   {28'h0, bus1.rid_o}, 32'h3);
    bus1.rready_i = 1; tick(); bus1.rready_i = 0;
    chk("v1_crc_o", crc1, 32'h2144DF1C);
    repeat (20) tick();
    chk("crc_zero", crc, crc_model());

    // incrementing burst across three registers
    wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333;
    ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
    do_write(4'h5, 32'h4, 2);
    do_read(4'h1, 32'h0, 4);

    // partial strobes
    wd[0] = 32'hAABBCCDD; ws[0] = 4'hF;
    do_write(4'h2, 32'h0, 0);
    wd[0] = 32'h0; ws[0] = 4'b0101;
    do_write(4'h2, 32'h0, 0);
    chk("v3_model", mem[0], 32'hAA00CC00);
    do_read(4'h4, 32'h0, 0);

    // burst running off the end of the register array
    wd[0] = 32'hCAFEF00D; wd[1] = 32'hDEADBEEF; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(4'h9, 32'h1C, 1);
    // CRC read right after a write goes through the wait path
    do_read(4'h6, 32'h20, 0);
    repeat (30) tick();
    chk("crc_after_v4", crc, crc_model());
    do_read(4'h7, 32'h18, 3);

    // randomized traffic
    for (int it = 0; it < 12; it++) begin
      int len;
      len = $urandom_range(0, 3);
      for (int k = 0; k <= len; k++) begin wd[k] = $urandom(); ws[k] = 4'($urandom()); end
      do_write(4'($urandom()), {$urandom_range(0, 10), 2'b00}, len);
      repeat (30) tick();
      chk("crc_rand", crc, crc_model());
      do_read(4'($urandom()), {$urandom_range(0, 10), 2'b00}, $urandom_range(0, 3));
    end

    // reset in the middle of a write burst
    bus.awid_i = 4'hA; bus.awaddr_i = 32'h0; bus.awlen_i = 3; bus.awvalid_i = 1;
    tick();
    bus.awvalid_i = 0;
    bus.wdata_i = 32'h12345678; bus.wstrb_i = 4'hF; bus.wvalid_i = 1;
    tick();
    areset = 0;
    #1;
    chk("v6_bvalid",  {31'h0, bus.bvalid_o}, 0);
    chk("v6_awready", {31'h0, bus.awready_o}, 1);
    chk("v6_wready",  {31'h0, bus.wready_o}, 0);
    chk("v6_crc",     crc, 0);
    idle_in();
    for (int i = 0; i < N; i++) mem[i] = '0;
    tick();
    areset = 1;
    repeat (30) tick();
    do_read(4'hB, 32'h0, N);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
